// File: rtl/pp_loop_pkg.sv
// Pipelined-loop controller shared types and constants.
// Also provides the expected start-to-finish latency.
package pp_loop_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_ITER  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_POST  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int POST_CYCLES = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_PRE   = S_PRE,
    ST_ITER  = S_ITER,
    ST_DRAIN = S_DRAIN,
    ST_POST  = S_POST,
    ST_DONE  = S_DONE
  } pp_state_e;

  // Cycles from start-accept edge to finish, no stall.
  function automatic int pp_latency(
    input int n,
    input int ii,
    input int depth
  );
    if (n == 0)
      return 2 + POST_CYCLES;
    return 2 + POST_CYCLES
           + (n - 1) * ii + depth;
  endfunction

endpackage

// File: rtl/pp_loop_ctrl_if.sv
// Control/status bundle of the pipelined-loop controller.
// master drives launch and stall; slave is the controller.
interface pp_loop_ctrl_if #(
  parameter int FSM_WIDTH = 3,
  parameter int CNT_W     = 16
);

  logic                 start;
  logic [CNT_W-1:0]     trip_count;
  logic                 stall;
  logic [FSM_WIDTH-1:0] cur_state;
  logic                 pre_states_valid;
  logic [2:0]           post_states_valid;
  logic                 iter_start_enable;
  logic                 iter_start_block;
  logic                 iter_end_enable;
  logic                 iter_end_block;
  logic                 quit_at_end;
  logic                 finish;
  logic                 busy;
  logic [CNT_W-1:0]     iter_idx;

  modport master (
    output start,
    output trip_count,
    output stall,
    input  cur_state,
    input  pre_states_valid,
    input  post_states_valid,
    input  iter_start_enable,
    input  iter_start_block,
    input  iter_end_enable,
    input  iter_end_block,
    input  quit_at_end,
    input  finish,
    input  busy,
    input  iter_idx
  );

  modport slave (
    input  start,
    input  trip_count,
    input  stall,
    output cur_state,
    output pre_states_valid,
    output post_states_valid,
    output iter_start_enable,
    output iter_start_block,
    output iter_end_enable,
    output iter_end_block,
    output quit_at_end,
    output finish,
    output busy,
    output iter_idx
  );

endinterface

// File: rtl/pp_loop_inflight.sv
// In-flight tracker: one bit per issued iteration,
// shifted each unstalled cycle; the top bit is its end.
module pp_loop_inflight #(
  parameter int DEPTH = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic push_i,
  output logic end_o,
  output logic busy_o
);

  localparam int W = (DEPTH > 1) ? DEPTH - 1 : 1;

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    sr_d    = sr_q << 1;
    sr_d[0] = push_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      sr_q <= '0;
    else if (en_i)
      sr_q <= sr_d;
  end

  // DEPTH=1 ends in the issue cycle, so nothing stays in flight.
  assign end_o  = (DEPTH == 1) ? push_i : sr_q[W-1];
  assign busy_o = (DEPTH == 1) ? 1'b0 : |sr_d;

endmodule

// File: rtl/pp_loop_ctrl.sv
// Pipelined-loop sequencer: PRE, issue every II cycles,
// drain the pipeline, three POST cycles, finish pulse.
import pp_loop_pkg::*;

module pp_loop_ctrl #(
  parameter int FSM_WIDTH = 3,
  parameter int CNT_W     = 16,
  parameter int II        = 2,
  parameter int DEPTH     = 5
) (
  input logic        clock,
  input logic        reset,
  pp_loop_ctrl_if.slave bus
);

  localparam int PH_W = (II > 1) ? $clog2(II) : 1;

  pp_state_e        state_q;
  logic [CNT_W-1:0] trip_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] idx_q;
  logic [PH_W-1:0]  ph_q;
  logic [1:0]       post_q;

  logic adv;
  logic iss_due;
  logic iss_fire;
  logic last_iss;
  logic end_due;
  logic end_fire;
  logic pend;

  assign adv      = !bus.stall;
  assign iss_due  = (state_q == ST_ITER) && (ph_q == '0);
  assign iss_fire = iss_due && adv;
  assign last_iss = (cnt_q == trip_q - CNT_W'(1));
  assign end_fire = end_due && adv;

  pp_loop_inflight #(
    .DEPTH (DEPTH)
  ) u_inflight (
    .clk_i  (clock),
    .rst_i  (reset),
    .en_i   (adv),
    .push_i (iss_due),
    .end_o  (end_due),
    .busy_o (pend)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      trip_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      ph_q    <= '0;
      post_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_PRE;
            trip_q  <= bus.trip_count;
            cnt_q   <= '0;
            idx_q   <= '0;
            ph_q    <= '0;
          end
        end
        ST_PRE: begin
          if (adv) begin
            post_q  <= '0;
            state_q <= (trip_q != '0)
                       ? ST_ITER : ST_POST;
          end
        end
        ST_ITER: begin
          if (adv) begin
            ph_q <= (ph_q == PH_W'(II - 1))
                    ? '0 : ph_q + PH_W'(1);
            if (iss_due) begin
              idx_q <= cnt_q;
              // count saturates on the final issue
              if (last_iss)
                state_q <= pend
                           ? ST_DRAIN : ST_POST;
              else
                cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (end_fire && !pend)
            state_q <= ST_POST;
        end
        ST_POST: begin
          if (adv) begin
            post_q <= post_q + 2'd1;
            if (post_q == 2'(POST_CYCLES - 1))
              state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (adv)
            state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cur_state         = FSM_WIDTH'(state_q);
  assign bus.pre_states_valid  = (state_q == ST_PRE);
  assign bus.post_states_valid = (state_q == ST_POST)
                                 ? (3'b001 << post_q)
                                 : 3'b000;
  assign bus.iter_start_enable = iss_fire;
  assign bus.iter_start_block  = iss_due && !adv;
  assign bus.iter_end_enable   = end_fire;
  assign bus.iter_end_block    = end_due && !adv;
  assign bus.quit_at_end       = end_fire && !pend &&
                                 ((state_q == ST_DRAIN) ||
                                  (iss_due && last_iss));
  assign bus.finish            = (state_q == ST_DONE) && adv;
  assign bus.busy              = (state_q != ST_IDLE);
  assign bus.iter_idx          = iss_fire ? cnt_q : idx_q;

endmodule

// File: tb/tb_pp_loop_ctrl.sv
// Bench for pp_loop_ctrl: two configurations driven in
// lockstep, checked each cycle against a timeline model.
import pp_loop_pkg::*;

module tb_pp_loop_ctrl;

  logic        clock;
  logic        reset;
  logic        s_start;
  logic [15:0] s_trip;
  logic        s_stall;

  int total;
  int bad;
  int cyc;

  pp_loop_ctrl_if #(.FSM_WIDTH(3), .CNT_W(16)) bus0 ();
  pp_loop_ctrl_if #(.FSM_WIDTH(3), .CNT_W(16)) bus1 ();

  assign bus0.start      = s_start;
  assign bus0.trip_count = s_trip;
  assign bus0.stall      = s_stall;
  assign bus1.start      = s_start;
  assign bus1.trip_count = s_trip;
  assign bus1.stall      = s_stall;

  pp_loop_ctrl #(
    .FSM_WIDTH (3),
    .CNT_W     (16),
    .II        (2),
    .DEPTH     (5)
  ) u_dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0.slave)
  );

  pp_loop_ctrl #(
    .FSM_WIDTH (3),
    .CNT_W     (16),
    .II        (1),
    .DEPTH     (1)
  ) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int st;
    bit pre;
    int post;
    bit is;
    bit isb;
    bit en;
    bit enb;
    bit q;
    bit fin;
    bit busy;
    int k;
  } exp_t;

  int IIV[2] = '{2, 1};
  int DV[2]  = '{5, 1};

  // Model state: run, unstalled cycles since accept, trip.
  bit run[2];
  int t[2];
  int n[2];
  bit clean[2];

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d",
               tag, cyc, got, exp);
    end
  endtask

  function automatic int fin_t(int nn, int ii, int d);
    if (nn == 0)
      return 5;
    return 5 + (nn - 1) * ii + d;
  endfunction

  function automatic exp_t model(
    bit rn, int tt, int nn, int ii, int d, bit stl
  );
    exp_t e;
    int   li;
    int   le;
    int   f;
    bit   idue;
    bit   edue;
    e = '{default: 0};
    if (!rn)
      return e;
    e.busy = 1;
    li = 2 + (nn - 1) * ii;
    le = li + d - 1;
    f  = fin_t(nn, ii, d);
    if (tt == 1) begin
      e.st  = 1;
      e.pre = 1;
    end else if (tt == f) begin
      e.st  = 5;
      e.fin = !stl;
    end else if (nn == 0) begin
      e.st   = 4;
      e.post = 1 << (tt - 2);
    end else if (tt > le) begin
      e.st   = 4;
      e.post = 1 << (tt - le - 1);
    end else if (tt <= li) begin
      e.st = 2;
    end else begin
      e.st = 3;
    end
    idue = nn > 0 && tt >= 2 && tt <= li &&
           ((tt - 2) % ii == 0);
    edue = nn > 0 && tt >= d + 1 && tt <= le &&
           ((tt - d - 1) % ii == 0);
    e.is  = idue && !stl;
    e.isb = idue && stl;
    e.en  = edue && !stl;
    e.enb = edue && stl;
    e.k   = idue ? (tt - 2) / ii : 0;
    e.q   = e.en && ((tt - d - 1) / ii == nn - 1);
    return e;
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        run[i]   = 0;
        clean[i] = 1;
      end else if (!run[i]) begin
        if (s_start) begin
          run[i]   = 1;
          t[i]     = 1;
          n[i]     = int'(s_trip);
          clean[i] = 0;
          chk($sformatf("u%0d.lat", i),
              pp_latency(n[i], IIV[i], DV[i]),
              fin_t(n[i], IIV[i], DV[i]));
        end
      end else if (!s_stall) begin
        if (t[i] == fin_t(n[i], IIV[i], DV[i]))
          run[i] = 0;
        else
          t[i]++;
      end
    end
  end

  task automatic check_one(
    input int          i,
    input logic [31:0] st,
    input logic [31:0] pre,
    input logic [31:0] post,
    input logic [31:0] is,
    input logic [31:0] isb,
    input logic [31:0] en,
    input logic [31:0] enb,
    input logic [31:0] q,
    input logic [31:0] fin,
    input logic [31:0] bsy,
    input logic [31:0] idx
  );
    exp_t  e;
    string p;
    e = model(run[i], t[i], n[i], IIV[i], DV[i],
              s_stall);
    p = $sformatf("u%0d.", i);
    chk({p, "state"}, st, e.st);
    chk({p, "pre"}, pre, 32'(e.pre));
    chk({p, "post"}, post, e.post);
    chk({p, "istart"}, is, 32'(e.is));
    chk({p, "iblock"}, isb, 32'(e.isb));
    chk({p, "iend"}, en, 32'(e.en));
    chk({p, "eblock"}, enb, 32'(e.enb));
    chk({p, "quit"}, q, 32'(e.q));
    chk({p, "finish"}, fin, 32'(e.fin));
    chk({p, "busy"}, bsy, 32'(e.busy));
    if (e.is)
      chk({p, "idx"}, idx, e.k);
    else if (clean[i])
      chk({p, "idx0"}, idx, 0);
  endtask

  task automatic check_all();
    check_one(0, 32'(bus0.cur_state),
      32'(bus0.pre_states_valid),
      32'(bus0.post_states_valid),
      32'(bus0.iter_start_enable),
      32'(bus0.iter_start_block),
      32'(bus0.iter_end_enable),
      32'(bus0.iter_end_block),
      32'(bus0.quit_at_end), 32'(bus0.finish),
      32'(bus0.busy), 32'(bus0.iter_idx));
    check_one(1, 32'(bus1.cur_state),
      32'(bus1.pre_states_valid),
      32'(bus1.post_states_valid),
      32'(bus1.iter_start_enable),
      32'(bus1.iter_start_block),
      32'(bus1.iter_end_enable),
      32'(bus1.iter_end_block),
      32'(bus1.quit_at_end), 32'(bus1.finish),
      32'(bus1.busy), 32'(bus1.iter_idx));
  endtask

  // Drive one cycle's inputs, check outputs, move on.
  task automatic step(
    input bit st, input int tc,
    input bit sl, input bit rs
  );
    s_start = st;
    s_trip  = tc[15:0];
    s_stall = sl;
    reset   = rs;
    #1;
    check_all();
    @(negedge clock);
    cyc++;
  endtask

  task automatic run_n(input int tc, input int len);
    for (int c = 0; c < len; c++)
      step(c == 0, tc, 0, 0);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    cyc     = 0;
    reset   = 1'b1;
    s_start = 1'b0;
    s_trip  = '0;
    s_stall = 1'b0;
    @(negedge clock);
    @(negedge clock);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    run_n(4, 20);
    run_n(0, 8);
    run_n(1, 10);
    for (int c = 0; c < 24; c++)
      step(c == 0, 4, c >= 4 && c <= 6, 0);
    for (int c = 0; c < 22; c++)
      step(c == 0 || c == 7, (c == 7) ? 9 : 4, 0, 0);
    for (int c = 0; c < 7; c++)
      step(c == 0, 4, 0, c == 5);
    run_n(3, 18);
    step(1, 32'hFFFF, 0, 0);
    for (int c = 0; c < 40; c++)
      step(0, 0, c % 7 == 3, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    for (int c = 0; c < 1500; c++)
      step($urandom_range(0, 5) == 0,
           $urandom_range(0, 6),
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 79) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
